// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine feeding the architectural HI/LO registers.
// Define MULDIV_DIV_EN to build the divide datapath; without it divides run the same timing but leave HI/LO alone.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH-1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 isdiv_q, isdiv_d;
  logic                 rsign_q, rsign_d;
  logic [WIDTH-1:0]     bmag_q, bmag_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d, dz_q, dz_d;

  logic                 sa, sb;
  logic [WIDTH-1:0]     amag, bmag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   prod;
`ifdef MULDIV_DIV_EN
  logic                 remsign_q, remsign_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH:0]       trial;
  logic [2*WIDTH-1:0]   div_next;
`endif

  always_comb begin
    sa      = op[0] & a[WIDTH-1];
    sb      = op[0] & b[WIDTH-1];
    amag    = sa ? -a : a;
    bmag    = sb ? -b : b;
    // acc holds {partial product, remaining multiplier bits}; shifts right each step
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, bmag_q} : '0);
    prod    = rsign_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
    // acc holds {partial remainder, dividend/quotient bits}; shifts left each step
    trial    = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, bmag_q};
    div_next = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                            : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`endif

    state_d = state_q;
    cnt_d   = cnt_q;
    isdiv_d = isdiv_q;
    rsign_d = rsign_q;
    bmag_d  = bmag_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
`ifdef MULDIV_DIV_EN
    remsign_d = remsign_q;
    a_d       = a_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d = CALC;
          cnt_d   = '0;
          isdiv_d = op[1];
          rsign_d = sa ^ sb;
          bmag_d  = bmag;
          acc_d   = {{WIDTH{1'b0}}, amag};
`ifdef MULDIV_DIV_EN
          remsign_d = sa;
          a_d       = a;
`endif
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) state_d = FIX;
          if (!isdiv_q) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
          else acc_d = div_next;
`endif
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!isdiv_q) begin
            {hi_d, lo_d} = prod;
          end
`ifdef MULDIV_DIV_EN
          else if (bmag_q == '0) begin
            lo_d = '1;
            hi_d = a_q;
            dz_d = 1'b1;
          end else begin
            lo_d = rsign_q   ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
            hi_d = remsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Direct MTHI/MTLO writes take priority over a same-edge result write.
    if (hi_we) hi_d = wdata;
    if (lo_we) lo_d = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      isdiv_q <= 1'b0;
      rsign_q <= 1'b0;
      bmag_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      remsign_q <= 1'b0;
      a_q       <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      isdiv_q <= isdiv_d;
      rsign_q <= rsign_d;
      bmag_q  <= bmag_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
`ifdef MULDIV_DIV_EN
      remsign_q <= remsign_d;
      a_q       <= a_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed and random ops against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst, start, flush, hi_we, lo_we;
  logic [1:0] op;
  logic [W-1:0] a, b, wdata, hi, lo;
  logic busy, done, dz;

  logic       s_start;
  logic [1:0] s_op;
  logic [7:0] s_a, s_b, s_hi, s_lo;
  logic       s_busy, s_done, s_dz;

  int unsigned total = 0;
  int unsigned passed = 0;
  logic [W-1:0] exp_hi, exp_lo, pend_hi, pend_lo;
  logic pend_dz;
  int k;
  bit seen;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s_start), .op(s_op), .a(s_a), .b(s_b), .flush(1'b0),
    .hi_we(1'b0), .lo_we(1'b0), .wdata(8'h00),
    .busy(s_busy), .done(s_done), .dz(s_dz), .hi(s_hi), .lo(s_lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Expected HI/LO/dz computed from the architectural definition of each op.
  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    longint sq, sr;
    pend_dz = 1'b0;
    pend_hi = exp_hi;
    pend_lo = exp_lo;
    if (!o[1]) begin
      if (o[0]) p = 64'(longint'($signed(x)) * longint'($signed(y)));
      else      p = {32'b0, x} * {32'b0, y};
      pend_hi = p[63:32];
      pend_lo = p[31:0];
    end else begin
`ifdef MULDIV_DIV_EN
      if (y == 0) begin
        pend_lo = '1;
        pend_hi = x;
        pend_dz = 1'b1;
      end else if (!o[0]) begin
        pend_lo = x / y;
        pend_hi = x % y;
      end else begin
        sq = longint'($signed(x)) / longint'($signed(y));
        sr = longint'($signed(x)) % longint'($signed(y));
        pend_lo = 32'(sq);
        pend_hi = 32'(sr);
      end
`endif
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge just after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    model(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic finish_op(input bit collide, input string tag);
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      if (collide && k == int'(W)) begin
        lo_we = 1'b1; wdata = 32'hA5A5_A5A5; pend_lo = 32'hA5A5_A5A5;
      end
      @(negedge clk);
      k++;
      lo_we = 1'b0;
    end
    check({tag, "_latency"}, 64'(k), 64'(W + 1));
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_dz"}, 64'(dz), 64'(pend_dz));
    check({tag, "_hi"}, 64'(hi), 64'(pend_hi));
    check({tag, "_lo"}, 64'(lo), 64'(pend_lo));
    exp_hi = pend_hi;
    exp_lo = pend_lo;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0;
    s_start = 1'b0; s_op = '0; s_a = '0; s_b = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // MTHI/MTLO, then an async reset in the middle of a multiply
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi", 64'(hi), 64'h1234_5678);
    check("mtlo", 64'(lo), 64'h1234_5678);
    exp_hi = 32'h1234_5678; exp_lo = 32'h1234_5678;
    issue(2'b00, 32'd5, 32'd7, "rstmid");
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_hi", 64'(hi), 64'd0);
    check("rstmid_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_hi = '0; exp_lo = '0;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
    check("rstmid_nodone", 64'(seen), 64'd0);

    // Directed multiply/divide cases
    issue(2'b01, 32'hFFFF_FFFD, 32'd4, "mult_m3x4");         finish_op(1'b0, "mult_m3x4");
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max"); finish_op(1'b0, "multu_max");
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, "div_m7d2");          finish_op(1'b0, "div_m7d2");
    issue(2'b10, 32'd100, 32'd0, "divu_dz");                 finish_op(1'b0, "divu_dz");
    @(negedge clk);
    check("dz_pulse", 64'(dz), 64'd0);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");   finish_op(1'b0, "div_ovf");

    // Flush mid-operation: no done, HI/LO retained, then a normal op
    issue(2'b01, 32'd1234, 32'hFFFF_FF00, "flush");
    repeat (14) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
    check("flush_nodone", 64'(seen), 64'd0);
    check("flush_hi", 64'(hi), 64'(exp_hi));
    check("flush_lo", 64'(lo), 64'(exp_lo));
    issue(2'b00, 32'd77, 32'd3, "post_flush"); finish_op(1'b0, "post_flush");

    // Flush and start together in IDLE: nothing starts
    flush = 1'b1; start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush_start_idle", 64'(busy), 64'd0);

    // MTLO colliding with the FIX write, then back-to-back issue in the done cycle
    issue(2'b00, 32'd2, 32'd3, "collide"); finish_op(1'b1, "collide");
    issue(2'b01, 32'hFFFF_FFF0, 32'd5, "b2b"); finish_op(1'b0, "b2b");

    // Random operations
    for (int i = 0; i < 20; i++) begin
      logic [1:0] ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = '0;
      if (i % 7 == 3) rb = '1;
      if (i % 4 == 1) ra = ra >> $urandom_range(0, 31);
      issue(ro, ra, rb, "rand");
      finish_op(1'b0, "rand");
    end

    // 8-bit instance: DIVU 200/7
    s_start = 1'b1; s_op = 2'b10; s_a = 8'd200; s_b = 8'd7;
    @(negedge clk);
    s_start = 1'b0;
    k = 0;
    while (s_done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    check("w8_latency", 64'(k), 64'd9);
    check("w8_dz", 64'(s_dz), 64'd0);
`ifdef MULDIV_DIV_EN
    check("w8_lo", 64'(s_lo), 64'd28);
    check("w8_hi", 64'(s_hi), 64'd4);
`else
    check("w8_lo", 64'(s_lo), 64'd0);
    check("w8_hi", 64'(s_hi), 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It sits beside the EX stage and executes MULT, MULTU, DIV and DIVU over multiple cycles. While it works, a busy flag stalls any HI/LO consumer. Results land in the HI/LO registers, which also accept direct MTHI/MTLO writes.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits; must be ≥ 4.
- CNT_W, $clog2(WIDTH+1): iteration counter width; derived, do not override.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only while busy=0.
- op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  in  WIDTH  multiplicand / dividend (rs).
- b  in  WIDTH  multiplier / divisor (rt).
- flush  in  1  cancel the in-flight operation (pipeline flush).
- hi_we  in  1  direct write to HI (MTHI).
- lo_we  in  1  direct write to LO (MTLO).
- wdata  in  WIDTH  data for hi_we / lo_we.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO updated this cycle.
- dz  out  1  one-cycle pulse with done when a divide had b==0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1, flush=0:
  - Latch the magnitudes of a and b; operands are taken as two's complement when op[0]=1.
  - Latch the result-sign and remainder-sign flags and the op.
  - Clear the counter; go to CALC; busy=1.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - After WIDTH steps, go to FIX.
- FIX: apply sign correction and write HI/LO; done=1; return to IDLE.
  - MULT/MULTU: {hi,lo} = 2·WIDTH-bit product, negated if the operand signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed divide: quotient is negative if the operand signs differ; the remainder takes the sign of the dividend.
  - Example: DIV −7/2 gives lo=−3, hi=−1.
- Divide by zero: no sign correction is applied; lo = all ones, hi = a as presented; dz=1 with done.
- Signed overflow (MIN / −1): lo=MIN, hi=0, dz=0.
- start while busy=1: ignored; no queueing.
- flush=1 in CALC or FIX: abort to IDLE on the next edge; no done; HI/LO unchanged. flush and start in the same IDLE cycle: flush wins, nothing starts.
- hi_we/lo_we: the target register takes wdata on the next edge in any state. If a direct write and the FIX write hit the same edge, the direct write wins for that register; the other register takes the result.
- Reset (rst=0, async, including mid-operation): state IDLE, hi=0, lo=0, busy=0, done=0, dz=0, counter=0.

## Timing
- Start accepted at edge E0. busy=1 from after E0 until after edge E0+WIDTH+1.
- CALC occupies edges E0+1 … E0+WIDTH. FIX is executed at edge E0+WIDTH+1.
- After edge E0+WIDTH+1: done=1 (dz if applicable), hi/lo valid, busy=0, all in the same cycle.
- Latency: WIDTH+1 cycles from the accept edge to valid HI/LO (33 for WIDTH=32).
- A new start may be asserted in the done cycle; it is accepted at that cycle's edge, giving back-to-back issue.
- done and dz are registered outputs; busy is decoded from state (≠IDLE) and is glitch-free.
- MTHI/MTLO: single-cycle; hi/lo reflect wdata after the write edge.

## Configuration
- MULDIV_DIV_EN defined: full unit as above.
- MULDIV_DIV_EN undefined:
  - Divide datapath, restoring logic and dz generation are removed; dz is tied to 0.
  - op 10/11 is accepted and completes through the normal state flow with identical timing: done pulses, HI/LO are not modified.
  - Multiply behaviour is unchanged.

## Test plan
- Reset mid-op: WIDTH=32, MULTU 5×7 started, rst low at cycle 10 → busy=0, hi=lo=0 immediately; no done follows.
- Multiply, WIDTH=32:
  - MULT a=−3 (0xFFFFFFFD), b=4 → done exactly 33 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFF4.
  - MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Divide, WIDTH=32:
  - DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=100, dz=1 coincident with done.
  - DIV 0x80000000/−1 → lo=0x80000000, hi=0, dz=0.
- Flush: MULT started, flush at cycle 15 → IDLE next cycle; no done; HI/LO retain prior values; a start 1 cycle later completes normally.
- Collision: lo_we=1, wdata=0xA5A5A5A5 in the FIX cycle of MULTU 2×3 → lo=0xA5A5A5A5, hi=0. start asserted in the done cycle → accepted.
- Parameter/config: WIDTH=8, DIVU 200/7 → lo=28, hi=4, done after 9 cycles. With MULDIV_DIV_EN undefined → done after 9 cycles, HI/LO unchanged, dz=0.
